key_arbiter: RTL and testbench
==============================

Name: key_arbiter

Overview:
- Sits between the 12 raw piano-key inputs and the key-to-note decoder.
- Synchronises and debounces each key, then arbitrates between held keys with last-pressed priority.
- Presents one 4-bit key index (0=C4 … 11=B) to the decoder, plus a note-on gate and a note-change strobe.
- The gate and strobe go to the tone generator, which reloads its divider from the decoder's note value.

Parameters:
- NUM_KEYS, 12, number of key inputs; fixed at 12 (matches decoder index range 0..11).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised key must differ from its debounced state before that state flips; legal range 2..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- keys_raw  input  12  raw key levels, 1 = pressed; bit i = key index i; asynchronous to clk.
- enable  input  1  1 = arbitration active; 0 = output muted.
- key_idx  output  4  selected key index to decoder, always in 0..11.
- note_on  output  1  gate, 1 while a note is selected and enable=1.
- note_change  output  1  one-cycle pulse when a new note starts or key_idx changes while playing.
- keys_held  output  12  debounced key state, for status/debug.

Behaviour:
- Reset (async assert, sync release via rst_n):
  - All sync flops, debounced states and counters = 0.
  - FSM = IDLE, key_idx = 0, note_on = 0, note_change = 0, keys_held = 0.
- Synchroniser: 2-flop per bit; sync2[i] is valid one edge after the first sampling edge.
- Debounce, per key, with counter width clog2(DEBOUNCE_CYCLES):
  - If sync2[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i]++.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
  - keys_held = deb.
- Events, derived from the previous-cycle copy of deb:
  - press[i] = deb[i] & ~deb_q[i].
  - release of the active key = ~deb[key_idx] while PLAY.
- FSM, registered, two states:
  - IDLE → PLAY when enable=1 and any press event: key_idx <= lowest-index pressing key; note_on <= 1; note_change pulse.
  - IDLE → PLAY also when enable=1 and any deb bit is set (covers enable rising while keys are held): key_idx <= lowest held key.
  - PLAY, press event on key k ≠ key_idx: key_idx <= lowest-index pressing key; note_change pulse. Last pressed wins; simultaneous presses resolve to the lowest index.
  - PLAY, active key released, no new press, other keys held: key_idx <= lowest-index held key; note_change pulse.
  - PLAY, active key released, no keys held: → IDLE, note_on <= 0. key_idx holds its last value (decoder output stable through release); no pulse.
  - PLAY, press and release of the active key in the same cycle: the press wins.
  - PLAY, enable=0: → IDLE the next edge, note_on <= 0, key_idx held. Debouncers keep running while enable=0.
- Latency: raw level change first sampled at edge N → deb flips at edge N+DEBOUNCE_CYCLES+1 → key_idx/note_on/note_change registered at edge N+DEBOUNCE_CYCLES+2 (default N+18).
- note_change is high for exactly one cycle per transition and never high while note_on=0.
- key_idx never exceeds 11; no other decoder input values are ever generated.
- Reset asserted mid-note: outputs clear immediately (asynchronously). After release the FSM re-enters PLAY only after keys re-debounce from 0.

Test Plan:
- Reset/idle: rst_n low with keys_raw=0x010 → key_idx=0, note_on=0, keys_held=0. Release reset, hold the key → note_on=1, key_idx=4 exactly 18 edges after the first sampling edge; note_change pulses once.
- Glitch rejection: key 7 high for 10 cycles then low → keys_held stays 0, note_on stays 0. Key 7 held for 16+ cycles → key_idx=7.
- Last-pressed priority with fallback:
  - Hold key 4 until playing, then press key 9 → key_idx=9 with a pulse.
  - Release key 9 → key_idx=4 with a pulse.
  - Release key 4 → note_on=0, key_idx stays 4, no pulse.
- Simultaneous press: keys 2 and 7 rise on the same cycle → key_idx=2, a single note_change pulse.
- Enable gating: while playing key 11, drop enable → note_on=0 next edge, key_idx=11. Raise enable with key 11 still held → note_on=1, key_idx=11, pulse.
- Async reset mid-note: pulse rst_n low between edges while playing key 5 → note_on=0, key_idx=0 immediately. After release, note_on returns 18 edges later with key_idx=5.

Source files
------------

// File: rtl/key_arbiter.sv
// Piano key front end: synchronises and debounces 12 raw keys, then picks one
// key index for the note decoder with last-pressed priority.
module key_arbiter #(
    parameter int NUM_KEYS        = 12,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                enable,
    output logic [3:0]          key_idx,
    output logic                note_on,
    output logic                note_change,
    output logic [NUM_KEYS-1:0] keys_held
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, deb, deb_q;
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] press;
    logic                active_rel;
    state_t              state, state_nxt;
    logic [3:0]          idx_nxt;
    logic                chg_nxt;

    function automatic logic [3:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // A key must disagree with its debounced level for DEBOUNCE_CYCLES
    // consecutive cycles before the debounced level follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press      = deb & ~deb_q;
    assign active_rel = ~deb[key_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_idx     <= '0;
            note_change <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_idx     <= idx_nxt;
            note_change <= chg_nxt;
        end
    end

    // A new press always beats a release of the active key in the same cycle;
    // on release with nothing new, fall back to the lowest key still held.
    always_comb begin
        state_nxt = state;
        idx_nxt   = key_idx;
        chg_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (|press) begin
                        state_nxt = PLAY;
                        idx_nxt   = lowest(press);
                        chg_nxt   = 1'b1;
                    end else if (|deb) begin
                        state_nxt = PLAY;
                        idx_nxt   = lowest(deb);
                        chg_nxt   = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (|press) begin
                    idx_nxt = lowest(press);
                    chg_nxt = (lowest(press) != key_idx);
                end else if (active_rel) begin
                    if (|deb) begin
                        idx_nxt = lowest(deb);
                        chg_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    assign note_on   = (state == PLAY);
    assign keys_held = deb;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed-vector bench for key_arbiter: reset, latency, debounce, priority,
// enable gating and asynchronous reset while a note is playing.
module tb_key_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] keys_raw;
    logic        enable;
    logic [3:0]  key_idx;
    logic        note_on;
    logic        note_change;
    logic [11:0] keys_held;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       name;
        logic [11:0] keys;
        logic        en;
        int          cycles;
        logic [3:0]  idx;
        logic        on;
        logic [11:0] held;
        int          pulses;
    } vec_t;

    vec_t vecs[$];

    key_arbiter #(.NUM_KEYS(12), .DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys_raw    (keys_raw),
        .enable      (enable),
        .key_idx     (key_idx),
        .note_on     (note_on),
        .note_change (note_change),
        .keys_held   (keys_held)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [11:0] k, input logic en);
        keys_raw = k;
        enable   = en;
    endtask

    // Advance n rising edges, sampling on each following falling edge.
    task automatic runCycles(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (note_change) pulses++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_idx,
                               input logic e_on, input logic [11:0] e_held,
                               input int e_p, input int a_p);
        n_vec++;
        if (key_idx !== e_idx || note_on !== e_on || keys_held !== e_held || a_p != e_p) begin
            n_miss++;
            $display("[TB] FAIL %s: got idx=%0d on=%0b held=%03h pulses=%0d, expected idx=%0d on=%0b held=%03h pulses=%0d",
                     name, key_idx, note_on, keys_held, a_p, e_idx, e_on, e_held, e_p);
        end
    endtask

    initial begin
        int p;

        vecs.push_back(vec_t'{"press9_priority",   12'h210, 1'b1, 20, 4'd9,  1'b1, 12'h210, 1});
        vecs.push_back(vec_t'{"release9_fallback", 12'h010, 1'b1, 20, 4'd4,  1'b1, 12'h010, 1});
        vecs.push_back(vec_t'{"release4_idle",     12'h000, 1'b1, 20, 4'd4,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"glitch7_high",      12'h080, 1'b1, 10, 4'd4,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"glitch7_low",       12'h000, 1'b1, 20, 4'd4,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"hold7",             12'h080, 1'b1, 20, 4'd7,  1'b1, 12'h080, 1});
        vecs.push_back(vec_t'{"release7",          12'h000, 1'b1, 20, 4'd7,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"simul_2_7",         12'h084, 1'b1, 20, 4'd2,  1'b1, 12'h084, 1});
        vecs.push_back(vec_t'{"release_2_7",       12'h000, 1'b1, 20, 4'd2,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"hold11",            12'h800, 1'b1, 20, 4'd11, 1'b1, 12'h800, 1});
        vecs.push_back(vec_t'{"enable_drop",       12'h800, 1'b0, 1,  4'd11, 1'b0, 12'h800, 0});
        vecs.push_back(vec_t'{"enable_low_hold",   12'h800, 1'b0, 5,  4'd11, 1'b0, 12'h800, 0});
        vecs.push_back(vec_t'{"enable_rise",       12'h800, 1'b1, 1,  4'd11, 1'b1, 12'h800, 1});
        vecs.push_back(vec_t'{"enable_steady",     12'h800, 1'b1, 3,  4'd11, 1'b1, 12'h800, 0});
        vecs.push_back(vec_t'{"swap_11_to_3",      12'h008, 1'b1, 20, 4'd3,  1'b1, 12'h008, 1});
        vecs.push_back(vec_t'{"release3",          12'h000, 1'b1, 20, 4'd3,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"hold4_again",       12'h010, 1'b1, 20, 4'd4,  1'b1, 12'h010, 1});
        vecs.push_back(vec_t'{"press_1_9",         12'h212, 1'b1, 20, 4'd1,  1'b1, 12'h212, 1});
        vecs.push_back(vec_t'{"release1_lowest",   12'h210, 1'b1, 20, 4'd4,  1'b1, 12'h210, 1});
        vecs.push_back(vec_t'{"release_all",       12'h000, 1'b1, 20, 4'd4,  1'b0, 12'h000, 0});
        vecs.push_back(vec_t'{"hold5",             12'h020, 1'b1, 20, 4'd5,  1'b1, 12'h020, 1});

        // Reset held with key 4 already down, then exact press latency.
        rst_n = 1'b0;
        applyStimulus(12'h010, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 4'd0, 1'b0, 12'h000, 0, int'(note_change));
        rst_n = 1'b1;
        runCycles(17, p);
        checkOutput("latency_deb_not_yet", 4'd0, 1'b0, 12'h000, 0, p);
        runCycles(1, p);
        checkOutput("latency_deb_flip", 4'd0, 1'b0, 12'h010, 0, p);
        runCycles(1, p);
        checkOutput("latency_note_on", 4'd4, 1'b1, 12'h010, 1, p);
        runCycles(1, p);
        checkOutput("pulse_one_cycle", 4'd4, 1'b1, 12'h010, 0, p);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].keys, vecs[i].en);
            runCycles(vecs[i].cycles, p);
            checkOutput(vecs[i].name, vecs[i].idx, vecs[i].on, vecs[i].held, vecs[i].pulses, p);
        end

        // Reset pulse between edges while key 5 plays, key stays down.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_clear", 4'd0, 1'b0, 12'h000, 0, int'(note_change));
        #1 rst_n = 1'b1;
        runCycles(18, p);
        checkOutput("post_reset_rebounce", 4'd0, 1'b0, 12'h020, 0, p);
        runCycles(1, p);
        checkOutput("post_reset_note_on", 4'd5, 1'b1, 12'h020, 1, p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
